// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store sequencer for a byte-addressed data memory.
//
// Accepts one load or store at a time from the core. It drives the memory's
// mem_read and mem_write strobes and returns a one-cycle response pulse. The
// memory always writes a full 32-bit word, so byte and halfword stores are
// done as read-modify-write. Load results are sign- or zero-extended according
// to the RISC-V funct3 encoding. Accesses that run past ADDR_LIMIT, and
// illegal funct3 codes, are rejected with resp_err.
//
// Optional build macro:
//   MISALIGN_TRAP_EN  misaligned LH/LHU/SH (addr[0]) and LW/SW (addr[1:0])
//                     are rejected with no memory strobe. When this macro is
//                     undefined, misaligned accesses proceed normally and
//                     only the range check applies.
//
// Parameters:
//   ADDR_LIMIT   data memory size in bytes; an access must have
//                addr + size <= ADDR_LIMIT.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  unit idle, request accepted on valid && ready edge
//   req_we       in   1 = store, 0 = load
//   req_funct3   in   access size / signedness (RISC-V encoding)
//   req_addr     in   byte address
//   req_wdata    in   store data (low bytes used for SB/SH)
//   resp_valid   out  one-cycle completion pulse
//   resp_rdata   out  extended load data; 0 for stores and errors
//   resp_err     out  request rejected (qualifies resp_valid)
//   mem_read     out  memory read strobe (RD state only)
//   mem_write    out  memory write strobe (WR state only)
//   mem_addr     out  memory byte address
//   mem_wdata    out  memory write word
//   mem_rdata    in   memory read word, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE = 3'd0;  // waiting for a request
  localparam logic [2:0] S_RD   = 3'd1;  // mem_read strobe
  localparam logic [2:0] S_CAP  = 3'd2;  // mem_rdata valid: extract or merge
  localparam logic [2:0] S_WR   = 3'd3;  // mem_write strobe
  localparam logic [2:0] S_ERR  = 3'd4;  // rejected request, one cycle

  // funct3 low bits encode the access size for both loads and stores.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The range limit is widened to 33 bits so that addr + size cannot wrap.
  localparam logic [32:0] LIMIT_33 = 33'(ADDR_LIMIT);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Number of bytes touched by an access of the given size code.
  function automatic logic [2:0] access_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: access_bytes = 3'd1;
      SZ_HALF: access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  // Pick the addressed bytes out of the memory word and extend them.
  // The byte at mem_addr always arrives on [7:0], so no lane shifting is needed.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [31:0] word);
    case (f3)
      3'b000:  load_extend = {{24{word[7]}},  word[7:0]};   // LB
      3'b001:  load_extend = {{16{word[15]}}, word[15:0]};  // LH
      3'b100:  load_extend = {24'h0,          word[7:0]};   // LBU
      3'b101:  load_extend = {16'h0,          word[15:0]};  // LHU
      default: load_extend = word;                          // LW
    endcase
  endfunction

  // Merge sub-word store data into the word read back from memory.
  // Only SB and SH reach this path; SW bypasses the read.
  function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                              input logic [31:0] old_word,
                                              input logic [31:0] new_data);
    if (f3[1:0] == SZ_HALF) begin
      store_merge = {old_word[31:16], new_data[15:0]};
    end else begin
      store_merge = {old_word[31:8], new_data[7:0]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;   // store data; holds the merged word for SB/SH

  // ---------------------------------------------------------------------------
  // Request classification (combinational, evaluated on the incoming request)
  // ---------------------------------------------------------------------------
  logic        funct3_bad;
  logic        range_bad;
  logic        misalign_bad;
  logic        req_bad;
  logic        req_full_store;  // SW: no read needed, straight to WR
  logic [32:0] req_end;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can leave a value held (no latch).
    funct3_bad   = 1'b0;
    range_bad    = 1'b0;
    misalign_bad = 1'b0;
    req_end      = 33'h0;

    // 011, 110 and 111 are illegal for both loads and stores; stores also
    // have no unsigned variants, so bit 2 set on a store is illegal.
    case (req_funct3)
      3'b011, 3'b110, 3'b111: funct3_bad = 1'b1;
      default:                funct3_bad = req_we & req_funct3[2];
    endcase

    req_end   = {1'b0, req_addr} + {30'h0, access_bytes(req_funct3[1:0])};
    range_bad = (req_end > LIMIT_33);

`ifdef MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      SZ_HALF: misalign_bad = req_addr[0];
      SZ_WORD: misalign_bad = |req_addr[1:0];
      default: misalign_bad = 1'b0;
    endcase
`else
    // The memory is byte-addressed, so misaligned accesses are legal.
    misalign_bad = 1'b0;
`endif
  end

  assign req_bad        = funct3_bad | range_bad | misalign_bad;
  assign req_full_store = req_we & (req_funct3[1:0] == SZ_WORD);

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // The request registers are cleared as well, so an operation cut short
      // by reset (including a half-merged word) leaves nothing behind.
      state      <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      // NOTE: all state here uses non-blocking assignment, so every register
      // sees the pre-edge value of every other register regardless of order.
      // The response is a single-cycle pulse; it is raised only on the
      // completing transition below.
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;

      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_bad) begin
              state <= S_ERR;
            end else if (req_full_store) begin
              state <= S_WR;
            end else begin
              // Loads, and SB/SH which must fetch the surrounding word first.
              state <= S_RD;
            end
          end
        end

        S_RD: begin
          state <= S_CAP;
        end

        S_CAP: begin
          if (we_q) begin
            wdata_q <= store_merge(funct3_q, mem_rdata, wdata_q);
            state   <= S_WR;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_extend(funct3_q, mem_rdata);
            state      <= S_IDLE;
          end
        end

        S_WR: begin
          resp_valid <= 1'b1;
          state      <= S_IDLE;
        end

        S_ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Strobes and the memory bus are decoded straight from the state register,
  // so an asynchronous reset drops them at once, before any pending WR edge.
  assign req_ready = (state == S_IDLE);
  assign mem_read  = (state == S_RD);
  assign mem_write = (state == S_WR);
  assign mem_addr  = (mem_read || mem_write) ? addr_q : 32'h0;
  assign mem_wdata = mem_write ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
//
// A byte-array memory model sits behind the unit. Expected responses are
// pushed to a scoreboard queue when a request is accepted and popped when
// resp_valid appears. Latency is measured in clock edges from the accept edge.
// Build with +define+MISALIGN_TRAP_EN to exercise the trapping configuration.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.ADDR_LIMIT(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Memory model: 256 bytes, initialised to mem[i] = i, registered read.
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [256];
  bit          mem_ready    = 1'b0;
  int          rd_count     = 0;
  int          wr_count     = 0;
  bit          overlap      = 1'b0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  function automatic logic [7:0] rb(input logic [31:0] a, input int k);
    logic [32:0] p;
    p = {1'b0, a} + 33'(k);
    return (p < 33'd256) ? mem[p[7:0]] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem_rdata <= 32'h0;
      mem_ready <= 1'b1;
    end else begin
      if (mem_read && mem_write) overlap <= 1'b1;
      if (mem_read) begin
        rd_count  <= rd_count + 1;
        mem_rdata <= {rb(mem_addr, 3), rb(mem_addr, 2), rb(mem_addr, 1), rb(mem_addr, 0)};
      end
      if (mem_write) begin
        wr_count     <= wr_count + 1;
        last_wr_addr <= mem_addr;
        last_wr_data <= mem_wdata;
        for (int k = 0; k < 4; k++) begin
          if (({1'b0, mem_addr} + 33'(k)) < 33'd256)
            mem[mem_addr[7:0] + 8'(k)] <= mem_wdata[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          n0;    // cycle count at the negedge before the accept edge
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic drive_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
  endtask

  // Present a request, wait for ready, push its expectation, then drop valid
  // on the negedge after the accept edge.
  task automatic send(input string name, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic err, input logic [31:0] rd, input int lat);
    int g = 0;
    drive_req(we, f3, a, wd);
    while (req_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      vectors++;
      errors++;
      $display("FAIL %s accept_timeout: req_ready=%b expected 1", name, req_ready);
    end
    sb_q.push_back('{err: err, rdata: rd, n0: cyc, lat: lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for resp_valid, pop the scoreboard and compare.
  task automatic collect(input string name);
    exp_t e;
    int   g = 0;
    while (resp_valid !== 1'b1 && g < 30) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_timeout: resp_valid=%b expected 1", name, resp_valid);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected_resp: queue empty", name);
      return;
    end
    e = sb_q.pop_front();
    vectors++;
    if (resp_err !== e.err) begin
      errors++;
      $display("FAIL %s resp_err: got %b expected %b", name, resp_err, e.err);
    end
    vectors++;
    if (resp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s resp_rdata: got %h expected %h", name, resp_rdata, e.rdata);
    end
    vectors++;
    if ((cyc - e.n0) != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, cyc - e.n0, e.lat);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s resp_pulse: resp_valid=%b one cycle later, expected 0", name, resp_valid);
    end
  endtask

  // One complete transaction plus strobe-count checks.
  task automatic run(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic err, input logic [31:0] rd, input int lat);
    int rc, wc, exp_rd, exp_wr;
    rc     = rd_count;
    wc     = wr_count;
    exp_rd = (!err && (!we || f3[1:0] != 2'b10)) ? 1 : 0;
    exp_wr = (!err && we) ? 1 : 0;
    send(name, we, f3, a, wd, err, rd, lat);
    collect(name);
    vectors++;
    if ((rd_count - rc) != exp_rd || (wr_count - wc) != exp_wr) begin
      errors++;
      $display("FAIL %s strobes: reads=%0d writes=%0d expected reads=%0d writes=%0d",
               name, rd_count - rc, wr_count - wc, exp_rd, exp_wr);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
        resp_rdata !== 32'h0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL %s idle_outputs: ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h expected 1,0,0,0,0,0,0,0",
               name, req_ready, resp_valid, resp_err, resp_rdata, mem_read,
               mem_write, mem_addr, mem_wdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_store_load();
    run("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
    vectors++;
    if (last_wr_addr !== 32'h10 || last_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_10 mem_bus: addr=%h data=%h expected 00000010 deadbeef", last_wr_addr, last_wr_data);
    end
    run("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3);
  endtask

  task automatic test_subword();
    run("sb_10", 1'b1, 3'b000, 32'h10, 32'h000000AA, 1'b0, 32'h0, 4);
    vectors++;
    if (last_wr_data !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL sb_10 merged: got %h expected deadbeaa", last_wr_data);
    end
    run("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFAA, 3);
    run("lbu_10", 1'b0, 3'b100, 32'h10, 32'h0, 1'b0, 32'h000000AA, 3);
    // Read at 0x12 returns {0x15, 0x14, 0xDE, 0xAD}; the low half is replaced.
    run("sh_12", 1'b1, 3'b001, 32'h12, 32'h00001234, 1'b0, 32'h0, 4);
    vectors++;
    if (last_wr_addr !== 32'h12 || last_wr_data !== 32'h15141234) begin
      errors++;
      $display("FAIL sh_12 merged: addr=%h data=%h expected 00000012 15141234", last_wr_addr, last_wr_data);
    end
    run("lw_10_after_sh", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h1234BEAA, 3);
    run("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'h00001234, 3);
    run("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000BEAA, 3);
    run("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFFBEAA, 3);
  endtask

  task automatic test_range_funct3();
    run("lw_253",    1'b0, 3'b010, 32'd253, 32'h0, 1'b1, 32'h0, 2);
    run("lw_252",    1'b0, 3'b010, 32'd252, 32'h0, 1'b0, 32'hFFFEFDFC, 3);
    run("lb_255",    1'b0, 3'b000, 32'd255, 32'h0, 1'b0, 32'hFFFFFFFF, 3);
    run("lbu_255",   1'b0, 3'b100, 32'd255, 32'h0, 1'b0, 32'h000000FF, 3);
    run("lh_254",    1'b0, 3'b001, 32'd254, 32'h0, 1'b0, 32'hFFFFFFFE, 3);
    run("sh_255",    1'b1, 3'b001, 32'd255, 32'h5555, 1'b1, 32'h0, 2);
    run("lb_wrap",   1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 2);
    run("sw_252",    1'b1, 3'b010, 32'd252, 32'h01020304, 1'b0, 32'h0, 2);
    run("lw_252_rb", 1'b0, 3'b010, 32'd252, 32'h0, 1'b0, 32'h01020304, 3);
    run("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 2);
    run("ld_f3_110", 1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0, 2);
    run("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, 2);
    run("st_f3_011", 1'b1, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 2);
  endtask

  task automatic test_misalign();
    // Bytes 0x10..0x14 are AA BE 34 12 14 at this point.
`ifdef MISALIGN_TRAP_EN
    run("lw_11", 1'b0, 3'b010, 32'h11, 32'h0, 1'b1, 32'h0, 2);
    run("lh_13", 1'b0, 3'b001, 32'h13, 32'h0, 1'b1, 32'h0, 2);
`else
    run("lw_11", 1'b0, 3'b010, 32'h11, 32'h0, 1'b0, 32'h141234BE, 3);
    run("lh_13", 1'b0, 3'b001, 32'h13, 32'h0, 1'b0, 32'h00001412, 3);
`endif
  endtask

  task automatic test_back_to_back();
    int g = 0;
    // A: LW 0x10. B: SW 0x40 held valid from the first busy cycle.
    drive_req(1'b0, 3'b010, 32'h10, 32'h0);
    sb_q.push_back('{err: 1'b0, rdata: 32'h1234BEAA, n0: cyc, lat: 3});
    @(negedge clk);
    drive_req(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    while (resp_valid !== 1'b1 && g < 30) begin
      vectors++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b busy_ready: req_ready=%b expected 0", req_ready);
      end
      @(negedge clk);
      g++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b resp_ready: req_ready=%b expected 1 during resp_valid", req_ready);
    end
    // B is accepted on the edge that ends A's response cycle.
    sb_q.push_back('{err: 1'b0, rdata: 32'h0, n0: cyc, lat: 2});
    collect("b2b_a");
    req_valid = 1'b0;
    collect("b2b_b");
    run("lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'hCAFEF00D, 3);
  endtask

  task automatic test_reset_mid_write();
    int wc;
    int g = 0;
    wc = wr_count;
    send("sb_20_rst", 1'b1, 3'b000, 32'h20, 32'h00000077, 1'b0, 32'h0, 4);
    while (mem_write !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h23222177) begin
      errors++;
      $display("FAIL rst_wr wr_state: wr=%b addr=%h wdata=%h expected 1 00000020 23222177",
               mem_write, mem_addr, mem_wdata);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_wr_async");
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    g = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) g++;
    end
    vectors++;
    if (g != 0) begin
      errors++;
      $display("FAIL rst_wr stray_resp: %0d resp_valid cycles expected 0", g);
    end
    vectors++;
    if (wr_count != wc || {mem[35], mem[34], mem[33], mem[32]} !== 32'h23222120) begin
      errors++;
      $display("FAIL rst_wr mem_unchanged: writes=%0d word=%h expected 0 23222120",
               wr_count - wc, {mem[35], mem[34], mem[33], mem[32]});
    end
    check_idle_outputs("rst_wr_after");
    run("lbu_20", 1'b0, 3'b100, 32'h20, 32'h0, 1'b0, 32'h00000020, 3);
  endtask

  task automatic test_strobes();
    vectors++;
    if (overlap !== 1'b0) begin
      errors++;
      $display("FAIL strobe_overlap: mem_read and mem_write seen high together");
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_subword();
    test_range_funct3();
    test_misalign();
    test_back_to_back();
    test_reset_mid_write();
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting directly upstream of the byte-addressed 256-byte data memory. It accepts one load or store request at a time from the core datapath and sequences the memory's `mem_read` and `mem_write` strobes. Because the memory always writes all four bytes, byte and halfword stores are done as read-modify-write. Load data is extracted and sign/zero-extended; out-of-range and illegal requests are rejected with an error response.

## Interface
- `ADDR_LIMIT`, default 256: data memory size in bytes. Any access must satisfy `addr + size <= ADDR_LIMIT`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access size, RISC-V encoding:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low bytes are used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`; request rejected.
- `mem_read`  out  1  to the memory's `mem_read`.
- `mem_write`  out  1  to the memory's `mem_write`.
- `mem_addr`  out  32  to the memory's `addr`.
- `mem_wdata`  out  32  to the memory's `write_data`.
- `mem_rdata`  in  32  from the memory's `read_data`.
  - Registered, valid the cycle after a `mem_read` cycle.
  - Byte at `mem_addr` is on `[7:0]`.

## Operation
- A request is accepted on a rising edge where `req_valid && req_ready`. On acceptance, `we`, `funct3`, `addr` and `wdata` are registered; inputs are ignored afterwards.
- States:
  - IDLE: `req_ready=1`.
  - RD: `mem_read=1`, `mem_addr` = registered address.
  - CAP: `mem_rdata` valid.
    - A load registers its result and goes to IDLE with a `resp_valid` pulse.
    - A SB/SH registers the merged word and goes to WR.
  - WR: `mem_write=1`, `mem_addr` and `mem_wdata` driven. Goes to IDLE with a `resp_valid` pulse.
  - ERR: one cycle, then IDLE with `resp_valid=1`, `resp_err=1`.
- Routing from IDLE on acceptance:
  - LW, LH, LHU, LB, LBU → RD.
  - SW → WR, with `mem_wdata = wdata`.
  - SB, SH → RD.
  - Invalid request → ERR.
- A request is invalid if any of the following holds:
  - funct3 is 011, 110 or 111;
  - store with funct3 bit 2 set;
  - `addr + size > ADDR_LIMIT`, where size is 1, 2 or 4 bytes. Compute the sum in 33 bits so it cannot wrap.
- Load extraction:
  - LB: sign-extend `[7:0]`.
  - LBU: zero-extend `[7:0]`.
  - LH: sign-extend `[15:0]`.
  - LHU: zero-extend `[15:0]`.
  - LW: `[31:0]`.
- Store merge:
  - SB: `{rdata[31:8], wdata[7:0]}`.
  - SH: `{rdata[31:16], wdata[15:0]}`.
- Strobes:
  - `mem_read` and `mem_write` are never high together, and never high outside RD and WR respectively.
  - `mem_addr` and `mem_wdata` are 0 in IDLE and ERR.
- `resp_valid` is high exactly one cycle per accepted request. That cycle coincides with `req_ready=1`, so a new request may be accepted on the same edge.

## Timing
- Reset values:
  - state IDLE, `req_ready=1`;
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`;
  - `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`.
- Latency, counted from the accept edge to the `resp_valid` cycle (registered `resp_*`):
  - load: valid after the 3rd edge;
  - SW: after the 2nd edge;
  - SB/SH: after the 4th edge;
  - error: after the 2nd edge.
- Reset mid-operation returns the unit to IDLE immediately and drops all strobes.
  - If `rst_n` falls before the WR edge, no memory write occurs.
  - A partially merged word is discarded.
- `req_ready` is 0 in RD, CAP, WR and ERR. A `req_valid` held during those states is not consumed.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - LH, LHU and SH with `addr[0]=1` take the ERR path with no memory strobe.
  - LW and SW with `addr[1:0]!=0` take the ERR path with no memory strobe.
- Undefined: misaligned accesses proceed normally, since the memory is byte-addressed. Only the range check applies.

## Test plan
- Reset, then SW addr 0x10, wdata 0xDEADBEEF:
  - `mem_write` pulses once with addr 0x10;
  - `resp_valid` comes 2 edges after accept with `resp_err=0`;
  - LW 0x10 then returns 0xDEADBEEF after 3 edges.
- After that store, SB addr 0x10, wdata 0x000000AA:
  - RD, then WR with `mem_wdata=0xDEADBEAA`;
  - LB 0x10 → 0xFFFFFFAA; LBU 0x10 → 0x000000AA.
- SH addr 0x12, wdata 0x1234 over 0xDEADBEAA:
  - memory word becomes 0x1234BEAA;
  - LH 0x12 → 0x00001234; LHU 0x10 → 0x0000BEAA.
- Range and funct3 checks:
  - LW addr 253 with `ADDR_LIMIT`=256 → `resp_err=1` after 2 edges, no strobes;
  - LB addr 255 → succeeds;
  - funct3=011 → error.
- Back-to-back:
  - new request held valid during `resp_valid` is accepted on that edge;
  - `rst_n` pulled low in the WR state of an SB → memory unchanged, `req_ready=1`, all outputs 0.
- Misalignment, LW addr 0x11:
  - with `MISALIGN_TRAP_EN` → error, no `mem_read`;
  - without it → returns bytes 0x11..0x14 assembled little-endian.
